// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator controller.
package csa_pkg;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RES = 2'd1,
    OUT = 2'd2
  } csa_acc_state_e;

  localparam int CSA_CNT_W_DEF = 8;

  // Largest value a CNT_W-bit beat counter can hold before it must stop counting.
  function automatic int unsigned beat_sat(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/cmprs_4to2.sv
// One row of 4:2 compressors; cout_b depends only on a/b/c so it can feed the next bit's cin without a ripple.
module cmprs_4to2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout_a,
  output logic [WIDTH-1:0] cout_b
);

  logic [WIDTH-1:0] s1;

  assign s1     = a ^ b ^ c;
  assign cout_b = (a & b) | (a & c) | (b & c);
  assign sum    = s1 ^ d ^ cin;
  assign cout_a = (s1 & d) | (s1 & cin) | (d & cin);

endmodule

// File: rtl/csa_acc_seq.sv
// Streams operand pairs into a carry-save accumulator and resolves it with one CPA after the last beat.
module csa_acc_seq
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = CSA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(beat_sat(CNT_W));

  csa_acc_state_e   state;
  logic [WIDTH-1:0] acc_s;
  logic [WIDTH-1:0] acc_c;
  logic [CNT_W-1:0] beat_cnt;
  logic [WIDTH-1:0] cmp_sum;
  logic [WIDTH-1:0] cout_a;
  logic [WIDTH-1:0] cout_b;
  logic [WIDTH-1:0] cin;
  logic             unused_msb;

  // Carries out of the top bit fall off the end: arithmetic is modulo 2^WIDTH.
  assign cin        = {cout_b[WIDTH-2:0], 1'b0};
  assign unused_msb = cout_a[WIDTH-1] ^ cout_b[WIDTH-1];

  cmprs_4to2 #(
    .WIDTH(WIDTH)
  ) u_row (
    .a     (acc_s),
    .b     (acc_c),
    .c     (in_a),
    .d     (in_b),
    .cin   (cin),
    .sum   (cmp_sum),
    .cout_a(cout_a),
    .cout_b(cout_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc_s     <= '0;
      acc_c     <= '0;
      beat_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
    end else begin
      unique case (state)
        ACC: begin
          if (in_valid && in_ready) begin
            acc_s <= cmp_sum;
            acc_c <= {cout_a[WIDTH-2:0], 1'b0};
            if (beat_cnt != BEAT_MAX) begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (in_last) begin
              state    <= RES;
              in_ready <= 1'b0;
            end
          end
        end
        // The CPA gets its own cycle so it never chains behind the compressor row.
        RES: begin
          out_sum   <= acc_s + acc_c;
          out_beats <= beat_cnt;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            acc_s     <= '0;
            acc_c     <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_acc_seq.sv
// Directed and randomized checks of csa_acc_seq at WIDTH=8, CNT_W=4 so wrap and saturation are reachable.
module tb_csa_acc_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_beats;

  int check_count = 0;
  int fail_count  = 0;

  csa_acc_seq #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_beats(out_beats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Presents one pair and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      step_clk();
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    step_clk();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect_result(input bit random_ready, output logic [WIDTH-1:0] sum,
                                output logic [CNT_W-1:0] beats);
    int guard = 0;
    bit done  = 1'b0;
    sum   = '0;
    beats = '0;
    while (!done && guard < 100) begin
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        sum   = out_sum;
        beats = out_beats;
        done  = 1'b1;
      end
      step_clk();
      guard++;
    end
    out_ready = 1'b0;
    if (!done) checkOutput("result_timeout", 0, 1);
  endtask

  task automatic run_txn(input logic [WIDTH-1:0] exp_sum, input int exp_beats, input string tag);
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] beats;
    collect_result(1'b0, sum, beats);
    checkOutput({tag, "_sum"}, int'(sum), int'(exp_sum));
    checkOutput({tag, "_beats"}, int'(beats), exp_beats);
    checkOutput({tag, "_in_ready_after"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [WIDTH-1:0] model_sum;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] got_sum;
    logic [CNT_W-1:0] got_beats;
    int               nbeats;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step_clk();
    step_clk();
    rst = 1'b0;

    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_sum", int'(out_sum), 0);
    checkOutput("reset_out_beats", int'(out_beats), 0);

    // Single beat: RES follows the accept edge, OUT the edge after it.
    applyStimulus(8'd5, 8'd7, 1'b1);
    checkOutput("single_res_out_valid", int'(out_valid), 0);
    checkOutput("single_res_in_ready", int'(in_ready), 0);
    step_clk();
    checkOutput("single_out_valid", int'(out_valid), 1);
    checkOutput("single_out_sum", int'(out_sum), 12);
    checkOutput("single_out_beats", int'(out_beats), 1);
    out_ready = 1'b1;
    step_clk();
    out_ready = 1'b0;
    checkOutput("single_after_out_valid", int'(out_valid), 0);
    checkOutput("single_after_in_ready", int'(in_ready), 1);
    checkOutput("single_after_sum_hold", int'(out_sum), 12);
    checkOutput("single_after_beats_hold", int'(out_beats), 1);

    applyStimulus(8'd1, 8'd2, 1'b0);
    applyStimulus(8'd3, 8'd4, 1'b0);
    applyStimulus(8'd5, 8'd6, 1'b1);
    checkOutput("three_in_ready_res", int'(in_ready), 0);
    step_clk();
    checkOutput("three_in_ready_out", int'(in_ready), 0);
    run_txn(8'd21, 3, "three");

    applyStimulus(8'hFF, 8'hFF, 1'b0);
    applyStimulus(8'h02, 8'h00, 1'b1);
    run_txn(8'h00, 2, "wrap");

    // Backpressure: the held result must not move and stray input pulses must not be taken.
    applyStimulus(8'd3, 8'd4, 1'b1);
    step_clk();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_a     = 8'd50;
      in_b     = 8'd60;
      in_last  = 1'b1;
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_out_sum", int'(out_sum), 7);
      checkOutput("bp_out_beats", int'(out_beats), 1);
      checkOutput("bp_in_ready", int'(in_ready), 0);
      step_clk();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    run_txn(8'd7, 1, "bp_release");
    applyStimulus(8'd9, 8'd1, 1'b1);
    run_txn(8'd10, 1, "bp_next");

    applyStimulus(8'd100, 8'd200, 1'b0);
    applyStimulus(8'd30, 8'd0, 1'b0);
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_out_sum", int'(out_sum), 0);
    checkOutput("midrst_out_beats", int'(out_beats), 0);
    applyStimulus(8'd10, 8'd0, 1'b1);
    run_txn(8'd10, 1, "midrst_next");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'd1, 8'd1, i == 19);
    end
    run_txn(8'd40, 15, "saturate");

    for (int t = 0; t < 2000; t++) begin
      model_sum = '0;
      nbeats    = $urandom_range(1, 18);
      for (int k = 0; k < nbeats; k++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step_clk();
        ra        = 8'($urandom_range(0, 255));
        rb        = 8'($urandom_range(0, 255));
        model_sum = model_sum + ra + rb;
        applyStimulus(ra, rb, k == nbeats - 1);
      end
      collect_result(1'b1, got_sum, got_beats);
      checkOutput("random_sum", int'(got_sum), int'(model_sum));
      checkOutput("random_beats", int'(got_beats), (nbeats > 15) ? 15 : nbeats);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
